div_share_ctrl: RTL and testbench

//   Round-robin arbiter and sequencer that shares one iterative 8-bit repeated-subtraction

---
 rtl/div_share_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_share_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Round-robin arbiter/sequencer that time-shares one iterative 8-bit divider among N_REQ requesters.
// Each job clears the divider, launches it, bounds the wait, and returns quotient/remainder to the winner.
module div_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 300
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_num,
    input  logic [8*N_REQ-1:0]   i_req_den,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [7:0]           o_rsp_res,
    output logic [7:0]           o_rsp_rem,
    output logic [1:0]           o_rsp_err,
    output logic                 o_busy,
    output logic                 o_div_rst,
    output logic                 o_div_start,
    output logic [7:0]           o_div_num,
    output logic [7:0]           o_div_den,
    input  logic [7:0]           i_div_res,
    input  logic [7:0]           i_div_rem,
    input  logic                 i_div_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [IDX_W-1:0]   w_cand_idx;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic               w_grant_found;
    logic               w_accept;
    logic               w_timeout;
    int                 w_cand;
    logic [7:0]         w_num_sel;
    logic [7:0]         w_den_sel;
    logic [7:0]         r_num;
    logic [7:0]         r_den;
    logic [7:0]         r_res;
    logic [7:0]         r_rem;
    logic [1:0]         r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_to_flag;

    // Scan from the highest rotated offset down so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = 0;
        w_cand_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand     = (int'(r_rr_ptr) + k) % N_REQ;
            w_cand_idx = IDX_W'(w_cand);
            if (i_req_valid[w_cand_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand_idx;
            end
        end
    end

    assign w_num_sel = i_req_num[{w_grant_idx, 3'b000} +: 8];
    assign w_den_sel = i_req_den[{w_grant_idx, 3'b000} +: 8];
    assign w_rr_nxt  = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: accept is gated by rst so no requester sees req_ready for a job that reset discards.
    assign w_accept = (r_state == S_IDLE) && w_grant_found && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_div_rst   = 1'b0;
        o_div_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    o_req_ready = N_REQ'(1) << w_grant_idx;
                    w_state_nxt = (w_den_sel == 8'd0) ? S_RESP : S_CLR;
                end
            end
            S_CLR: begin
                o_div_rst   = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: begin
                o_div_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_div_done || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_div_rst   = r_to_flag;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_num     <= '0;
            r_den     <= '0;
            r_res     <= '0;
            r_rem     <= '0;
            r_err     <= ERR_OK;
            r_cnt     <= '0;
            r_to_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num    <= w_num_sel;
                        r_den    <= w_den_sel;
                        r_grant  <= w_grant_idx;
                        r_rr_ptr <= w_rr_nxt;
                        if (w_den_sel == 8'd0) begin
                            r_res <= 8'hFF;
                            r_rem <= w_num_sel;
                            r_err <= ERR_DIV0;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_div_done) begin
                        r_res <= i_div_res;
                        r_rem <= i_div_rem;
                        r_err <= ERR_OK;
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_res     <= '0;
                        r_rem     <= '0;
                        r_err     <= ERR_TOUT;
                        r_to_flag <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: r_to_flag <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_rsp_valid = (r_state == S_RESP && !rst) ? (N_REQ'(1) << r_grant) : '0;
    assign o_rsp_res   = r_res;
    assign o_rsp_rem   = r_rem;
    assign o_rsp_err   = r_err;
    assign o_busy      = (r_state != S_IDLE);
    assign o_div_num   = r_num;
    assign o_div_den   = r_den;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a repeated-subtraction divider model whose quotient
// is cleared only by its reset, so a missing clear shows up as a stale, accumulated quotient.
module tb_div_share_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_num = '0;
    logic [31:0] req_den = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_res;
    logic [7:0]  rsp_rem;
    logic [1:0]  rsp_err;
    logic        busy;
    logic        div_rst;
    logic        div_start;
    logic [7:0]  div_num;
    logic [7:0]  div_den;
    logic [7:0]  m_res;
    logic [7:0]  m_rem;
    logic        m_busy;
    logic        m_done;
    logic        hang = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_divrst = 0;

    always #5 clk = ~clk;

    div_share_ctrl #(.N_REQ(4), .TIMEOUT(300)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .i_req_num   (req_num),
        .i_req_den   (req_den),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_res   (rsp_res),
        .o_rsp_rem   (rsp_rem),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy),
        .o_div_rst   (div_rst),
        .o_div_start (div_start),
        .o_div_num   (div_num),
        .o_div_den   (div_den),
        .i_div_res   (m_res),
        .i_div_rem   (m_rem),
        .i_div_done  (m_done)
    );

    // Divider model: done appears q+1 cycles after the start pulse; quotient accumulates until reset.
    always @(posedge clk) begin
        if (rst || div_rst) begin
            m_res  <= '0;
            m_rem  <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (div_start) begin
            m_done <= 1'b0;
            if (div_den == 8'd0) begin
                m_busy <= 1'b0;
            end else if (div_num >= div_den) begin
                m_rem  <= div_num - div_den;
                m_res  <= m_res + 8'd1;
                m_busy <= 1'b1;
            end else begin
                m_rem  <= div_num;
                m_busy <= 1'b0;
                m_done <= !hang;
            end
        end else if (m_busy) begin
            if (m_rem >= div_den) begin
                m_rem <= m_rem - div_den;
                m_res <= m_res + 8'd1;
            end else begin
                m_busy <= 1'b0;
                m_done <= !hang;
            end
        end
    end

    always @(posedge clk) begin
        if (div_start) n_start <= n_start + 1;
        if (div_rst)   n_divrst <= n_divrst + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one job, waits for acceptance, scrambles the inputs, then times the response.
    task automatic run_job(input int idx, input logic [7:0] num, input logic [7:0] den,
                           output logic [3:0] rdy_vec, output int lat,
                           output logic [7:0] res, output logic [7:0] rem,
                           output logic [1:0] err, output logic [3:0] rsp_vec);
        rdy_vec = '0;
        lat     = -1;
        res     = '0;
        rem     = '0;
        err     = '0;
        rsp_vec = '0;
        @(negedge clk);
        req_valid[idx]        = 1'b1;
        req_num[idx*8 +: 8]   = num;
        req_den[idx*8 +: 8]   = den;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != '0) begin
                rdy_vec = req_ready;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[idx]      = 1'b0;
        req_num[idx*8 +: 8] = 8'hAA;
        req_den[idx*8 +: 8] = 8'h00;
        if (rdy_vec != '0) begin
            for (int k = 1; k <= 400; k++) begin
                #1;
                if (rsp_valid != '0) begin
                    lat     = k;
                    res     = rsp_res;
                    rem     = rsp_rem;
                    err     = rsp_err;
                    rsp_vec = rsp_valid;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({busy, req_ready, rsp_valid, div_rst, div_start} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want all zero",
                     {busy, req_ready, rsp_valid, div_rst, div_start});
        end
        n_checks++;
        if ({rsp_res, rsp_rem, rsp_err, div_num, div_den} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 0", {rsp_res, rsp_rem, rsp_err, div_num, div_den});
        end
    endtask

    task automatic test_single();
        logic [3:0] rv, sv;
        logic [7:0] res, rem;
        logic [1:0] err;
        int lat;
        run_job(0, 8'd100, 8'd7, rv, lat, res, rem, err, sv);
        n_checks++;
        if (rv !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b, want 0001", rv); end
        n_checks++;
        if (lat != 18) begin n_fail++; $display("FAIL single_latency: got %0d, want 18", lat); end
        n_checks++;
        if (res !== 8'd14 || rem !== 8'd2 || err !== 2'b00) begin
            n_fail++;
            $display("FAIL single_result: got res=%0d rem=%0d err=%b, want 14 2 00", res, rem, err);
        end
        n_checks++;
        if (sv !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_vec: got %b, want 0001", sv); end
    endtask

    task automatic test_stale();
        logic [3:0] rv, sv;
        logic [7:0] res, rem;
        logic [1:0] err;
        int lat;
        run_job(1, 8'd20, 8'd5, rv, lat, res, rem, err, sv);
        n_checks++;
        if (res !== 8'd4 || rem !== 8'd0 || lat != 8) begin
            n_fail++;
            $display("FAIL stale_first: got res=%0d rem=%0d lat=%0d, want 4 0 8", res, rem, lat);
        end
        run_job(1, 8'd9, 8'd3, rv, lat, res, rem, err, sv);
        n_checks++;
        if (res !== 8'd3 || rem !== 8'd0 || lat != 7) begin
            n_fail++;
            $display("FAIL stale_second: got res=%0d rem=%0d lat=%0d, want 3 0 7", res, rem, lat);
        end
        n_checks++;
        if (sv !== 4'b0010) begin n_fail++; $display("FAIL stale_rsp_vec: got %b, want 0010", sv); end
    endtask

    task automatic test_div_zero();
        logic [3:0] rv, sv;
        logic [7:0] res, rem;
        logic [1:0] err;
        int lat, starts0, rsts0;
        starts0 = n_start;
        rsts0   = n_divrst;
        run_job(2, 8'd55, 8'd0, rv, lat, res, rem, err, sv);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL div0_latency: got %0d, want 1", lat); end
        n_checks++;
        if (res !== 8'hFF || rem !== 8'd55 || err !== 2'b01) begin
            n_fail++;
            $display("FAIL div0_result: got res=%h rem=%0d err=%b, want FF 55 01", res, rem, err);
        end
        n_checks++;
        if (sv !== 4'b0100 || rv !== 4'b0100) begin
            n_fail++;
            $display("FAIL div0_vectors: got ready=%b rsp=%b, want 0100 0100", rv, sv);
        end
        n_checks++;
        if (n_start != starts0 || n_divrst != rsts0) begin
            n_fail++;
            $display("FAIL div0_untouched: got %0d starts %0d resets, want 0 0",
                     n_start - starts0, n_divrst - rsts0);
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] rv, sv;
        logic [7:0] res, rem;
        logic [1:0] err;
        int lat;
        run_job(3, 8'd255, 8'd1, rv, lat, res, rem, err, sv);
        n_checks++;
        if (res !== 8'd255 || rem !== 8'd0 || lat != 259) begin
            n_fail++;
            $display("FAIL max_quot: got res=%0d rem=%0d lat=%0d, want 255 0 259", res, rem, lat);
        end
        run_job(0, 8'd3, 8'd9, rv, lat, res, rem, err, sv);
        n_checks++;
        if (res !== 8'd0 || rem !== 8'd3 || lat != 4) begin
            n_fail++;
            $display("FAIL num_lt_den: got res=%0d rem=%0d lat=%0d, want 0 3 4", res, rem, lat);
        end
        run_job(1, 8'd7, 8'd7, rv, lat, res, rem, err, sv);
        n_checks++;
        if (res !== 8'd1 || rem !== 8'd0 || lat != 5) begin
            n_fail++;
            $display("FAIL num_eq_den: got res=%0d rem=%0d lat=%0d, want 1 0 5", res, rem, lat);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] rv, sv;
        logic [7:0] res, rem;
        logic [1:0] err;
        int lat, rsts0;
        hang  = 1'b1;
        rsts0 = n_divrst;
        run_job(3, 8'd10, 8'd2, rv, lat, res, rem, err, sv);
        @(negedge clk);
        hang = 1'b0;
        n_checks++;
        if (lat != 303) begin n_fail++; $display("FAIL timeout_latency: got %0d, want 303", lat); end
        n_checks++;
        if (res !== 8'd0 || rem !== 8'd0 || err !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_result: got res=%0d rem=%0d err=%b, want 0 0 10", res, rem, err);
        end
        n_checks++;
        if (n_divrst - rsts0 != 2) begin
            n_fail++;
            $display("FAIL timeout_div_rst: got %0d pulses, want 2 (clear + abort)", n_divrst - rsts0);
        end
    endtask

    task automatic test_round_robin();
        int grants[5];
        logic [3:0] rsps[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int ng = 0;
        int nr = 0;
        int bad_data = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            grants[i] = -1;
            rsps[i]   = '0;
        end
        @(negedge clk);
        req_num   = {4{8'd8}};
        req_den   = {4{8'd2}};
        req_valid = 4'b1111;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (req_ready != '0 && ng < 5) begin
                for (int b = 0; b < 4; b++) if (req_ready[b]) grants[ng] = b;
                ng++;
            end
            if (rsp_valid != '0) begin
                rsps[nr] = rsp_valid;
                if (rsp_res !== 8'd4 || rsp_rem !== 8'd0) bad_data++;
                nr++;
                if (nr == 5) break;
            end
            @(negedge clk);
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (grants[i] != exp_order[i] || rsps[i] !== (4'b0001 << exp_order[i])) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got grant=%0d rsp=%b, want %0d %b",
                         i, grants[i], rsps[i], exp_order[i], 4'b0001 << exp_order[i]);
            end
        end
        n_checks++;
        if (bad_data != 0 || nr != 5) begin
            n_fail++;
            $display("FAIL rr_data: got %0d bad results over %0d responses, want 0 over 5", bad_data, nr);
        end
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0;
        @(negedge clk);
        req_valid[1]   = 1'b1;
        req_num[15:8]  = 8'd200;
        req_den[15:8]  = 8'd1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL midrst_accept: got %b, want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b, want 0", busy); end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != '0) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d pulses, want 0", pulses); end
        @(negedge clk);
        req_num   = {8'd6, 8'd0, 8'd0, 8'd6};
        req_den   = {8'd3, 8'd0, 8'd0, 8'd3};
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_rr_ptr: got %b, want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale();
        test_div_zero();
        test_boundaries();
        test_timeout();
        test_round_robin();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
